// File: rtl/osc_meas_pkg.sv
// osc_meas_pkg: shared types and defaults for the oscillator
// measurement sequencer (state encoding, channel defaults).
package osc_meas_pkg;

    localparam int CNT_W_DEF = 32;
    localparam int N_CH_DEF  = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GATE  = 3'd1,
        ST_LATCH = 3'd2,
        ST_SEND  = 3'd3,
        ST_HALT  = 3'd4
    } state_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/osc_meas_seq_if.sv
// osc_meas_seq_if: counter-latch bus and UART frame handshake.
// master = sequencer (latch_req, tx_start, tx_data out);
// slave  = counters/UART (latch_ack, cnt_latch, tx_busy, tx_done out).
interface osc_meas_seq_if
    import osc_meas_pkg::*;
#(
    parameter int N_CH  = N_CH_DEF,
    parameter int CNT_W = CNT_W_DEF
) ();

    logic                    latch_req;
    logic [N_CH-1:0]         latch_ack;
    logic [N_CH*CNT_W-1:0]   cnt_latch;
    logic                    tx_start;
    logic [N_CH*CNT_W-1:0]   tx_data;
    logic                    tx_busy;
    logic                    tx_done;

    modport master (
        output latch_req,
        output tx_start,
        output tx_data,
        input  latch_ack,
        input  cnt_latch,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  latch_req,
        input  tx_start,
        input  tx_data,
        output latch_ack,
        output cnt_latch,
        output tx_busy,
        output tx_done
    );

endinterface

// File: rtl/osc_win_timer.sv
// osc_win_timer: loadable down-counter, saturates at zero.
// ports: ref_clk, rst, load_i/val_i (load), tc_o (count is zero).
module osc_win_timer #(
    parameter int TW = 8
) (
    input  logic          ref_clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [TW-1:0] val_i,
    output logic          tc_o
);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - TW'(1);
        end
    end

    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/osc_meas_seq.sv
// osc_meas_seq: gate/latch/send/halt sequencer for oscillator counters.
// ports: ref_clk, rst, enable, osc_rst, osc_halt, sample_idx, tmo_err, bus.
module osc_meas_seq
    import osc_meas_pkg::*;
#(
    parameter int GATE_CYC = 10_000_000,
    parameter int N_CH     = N_CH_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int STP_SMPL = 30,
    parameter int HALT_WIN = 1,
    parameter int ACK_TMO  = 64,
    localparam int SIW = (STP_SMPL > 1) ? $clog2(STP_SMPL) : 1
) (
    input  logic           ref_clk,
    input  logic           rst,
    input  logic           enable,
    output logic           osc_rst,
    output logic           osc_halt,
    output logic [SIW-1:0] sample_idx,
    output logic           tmo_err,
    osc_meas_seq_if.master bus
);

    localparam int W        = N_CH * CNT_W;
    localparam int HALT_CYC = GATE_CYC * HALT_WIN;
    localparam int TMAX     = max2(HALT_CYC, max2(GATE_CYC, ACK_TMO));
    localparam int TW       = $clog2(TMAX + 1);

    // Timer is loaded with length-1 so tc marks the last cycle.
    localparam logic [TW-1:0] GATE_LD = TW'(GATE_CYC - 1);
    localparam logic [TW-1:0] ACK_LD  = TW'(ACK_TMO - 1);
    localparam logic [TW-1:0] HALT_LD = TW'(HALT_CYC - 1);
    localparam logic [SIW:0]  STP_LIM = (SIW + 1)'(STP_SMPL);

    state_e         state_q, state_d;
    logic [SIW-1:0] idx_q, idx_d;
    logic [SIW:0]   idx_inc;
    logic [W-1:0]   data_q, data_d;
    logic [W-1:0]   snap;
    logic           err_q, err_d;
    logic           started_q, started_d;
    logic           tx_start_c;
    logic           osc_rst_q, osc_halt_q, latch_req_q;
    logic           tmr_load;
    logic [TW-1:0]  tmr_val;
    logic           tmr_tc;

    osc_win_timer #(
        .TW (TW)
    ) u_tmr (
        .ref_clk (ref_clk),
        .rst     (rst),
        .load_i  (tmr_load),
        .val_i   (tmr_val),
        .tc_o    (tmr_tc)
    );

    // Unacked channels read as all-ones so a stuck
    // counter is visible in the frame.
    always_comb begin
        snap = '0;
        for (int c = 0; c < N_CH; c++) begin
            snap[c*CNT_W +: CNT_W] = bus.latch_ack[c]
                ? bus.cnt_latch[c*CNT_W +: CNT_W]
                : {CNT_W{1'b1}};
        end
    end

    assign idx_inc = {1'b0, idx_q} + (SIW + 1)'(1);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        data_d     = data_q;
        err_d      = err_q;
        started_d  = 1'b0;
        tx_start_c = 1'b0;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        unique case (state_q)
            ST_IDLE: begin
                idx_d = '0;
                if (enable) begin
                    state_d  = ST_GATE;
                    tmr_load = 1'b1;
                    tmr_val  = GATE_LD;
                end
            end
            ST_GATE: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else if (tmr_tc) begin
                    state_d  = ST_LATCH;
                    tmr_load = 1'b1;
                    tmr_val  = ACK_LD;
                end
            end
            ST_LATCH: begin
                if (&bus.latch_ack) begin
                    data_d  = snap;
                    state_d = ST_SEND;
                end else if (tmr_tc) begin
                    data_d  = snap;
                    err_d   = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                // tx_done is only honoured once our start went out.
                tx_start_c = !started_q && !bus.tx_busy;
                started_d  = started_q || tx_start_c;
                if (started_q && bus.tx_done) begin
                    if (!enable) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end else if (idx_inc == STP_LIM) begin
                        state_d  = ST_HALT;
                        idx_d    = '0;
                        tmr_load = 1'b1;
                        tmr_val  = HALT_LD;
                    end else begin
                        state_d  = ST_GATE;
                        idx_d    = idx_inc[SIW-1:0];
                        tmr_load = 1'b1;
                        tmr_val  = GATE_LD;
                    end
                end
            end
            ST_HALT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else if (tmr_tc) begin
                    state_d  = ST_GATE;
                    tmr_load = 1'b1;
                    tmr_val  = GATE_LD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Control outputs are registered from the next state so
    // they line up with state_q without a decode glitch.
    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            data_q      <= '0;
            err_q       <= 1'b0;
            started_q   <= 1'b0;
            osc_rst_q   <= 1'b1;
            osc_halt_q  <= 1'b0;
            latch_req_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            err_q       <= err_d;
            started_q   <= started_d;
            osc_rst_q   <= (state_d == ST_IDLE) ||
                           (state_d == ST_SEND) ||
                           (state_d == ST_HALT);
            osc_halt_q  <= (state_d == ST_HALT);
            latch_req_q <= (state_d == ST_LATCH);
        end
    end

    assign osc_rst       = osc_rst_q;
    assign osc_halt      = osc_halt_q;
    assign sample_idx    = idx_q;
    assign tmo_err       = err_q;
    assign bus.latch_req = latch_req_q;
    assign bus.tx_start  = tx_start_c;
    assign bus.tx_data   = data_q;

endmodule

// File: tb/tb_osc_meas_seq.sv
// tb_osc_meas_seq: directed bench for osc_meas_seq with
// small gate/halt windows and a scripted counter/UART side.
module tb_osc_meas_seq;

    localparam int GC = 100;
    localparam int NC = 2;
    localparam int CW = 32;
    localparam int SS = 3;
    localparam int HW = 2;
    localparam int AT = 8;

    logic       ref_clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       osc_rst;
    logic       osc_halt;
    logic       tmo_err;
    logic [1:0] sample_idx;

    int n_tot   = 0;
    int n_pass  = 0;
    int n_start = 0;
    int n_halt  = 0;

    osc_meas_seq_if #(.N_CH(NC), .CNT_W(CW)) bus ();

    osc_meas_seq #(
        .GATE_CYC (GC),
        .N_CH     (NC),
        .CNT_W    (CW),
        .STP_SMPL (SS),
        .HALT_WIN (HW),
        .ACK_TMO  (AT)
    ) dut (
        .ref_clk    (ref_clk),
        .rst        (rst),
        .enable     (enable),
        .osc_rst    (osc_rst),
        .osc_halt   (osc_halt),
        .sample_idx (sample_idx),
        .tmo_err    (tmo_err),
        .bus        (bus)
    );

    always #5 ref_clk = ~ref_clk;

    always @(negedge ref_clk) begin
        if (bus.tx_start) n_start++;
        if (osc_halt) n_halt++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge ref_clk);
        #1;
    endtask

    function automatic logic sig(input int s);
        case (s)
            0:       return bus.latch_req;
            1:       return !bus.latch_req;
            2:       return !osc_halt;
            default: return 1'b1;
        endcase
    endfunction

    task automatic wait_for(input int s, input int max,
                            output int n, output bit hit);
        n = 0;
        hit = 1'b0;
        while (!hit && n < max) begin
            tick();
            n++;
            hit = sig(s);
        end
    endtask

    task automatic sample(input logic [1:0] am, input int busy,
                          input bit spur, input bit drop,
                          output int gn, output int ln, output int sn);
        int n;
        int s0;
        bit hit;
        wait_for(0, 300, gn, hit);
        chk("latch_seen", hit, 1);
        tick();
        tick();
        bus.latch_ack = am;
        bus.tx_busy   = (busy > 0);
        wait_for(1, 20, n, hit);
        chk("latch_end", hit, 1);
        ln = n + 2;
        bus.latch_ack = '0;
        s0 = n_start;
        for (int c = 1; c <= busy; c++) begin
            bus.tx_done = spur && (c == busy / 2);
            tick();
        end
        bus.tx_done = 1'b0;
        if (drop) enable = 1'b0;
        bus.tx_busy = 1'b0;
        #1;
        chk("start_now", bus.tx_start, 1);
        chk("no_early_start", n_start - s0, 0);
        tick();
        chk("start_drop", bus.tx_start, 0);
        bus.tx_busy = 1'b1;
        tick();
        tick();
        tick();
        bus.tx_busy = 1'b0;
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        sn = n_start - s0;
    endtask

    initial begin
        int gn, ln, sn, n, h0, s0;
        bit hit;
        rst           = 1'b1;
        enable        = 1'b0;
        bus.latch_ack = '0;
        bus.cnt_latch = {32'h0000_0022, 32'h0000_0011};
        bus.tx_busy   = 1'b0;
        bus.tx_done   = 1'b0;
        tick();
        tick();
        chk("rst_ctl", {osc_rst, osc_halt, bus.latch_req,
                        bus.tx_start, tmo_err}, 5'b10000);
        chk("rst_data", bus.tx_data, 0);
        chk("rst_idx", sample_idx, 0);
        rst = 1'b0;
        tick();
        tick();
        chk("idle_hold", {osc_rst, bus.latch_req}, 2'b10);

        enable = 1'b1;
        tick();
        chk("gate_entry", osc_rst, 0);
        sample(2'b11, 0, 1'b0, 1'b0, gn, ln, sn);
        chk("s1_gate", gn, 100);
        chk("s1_latch", ln, 3);
        chk("s1_data", bus.tx_data, 64'h00000022_00000011);
        chk("s1_starts", sn, 1);
        chk("s1_idx", sample_idx, 1);
        chk("s1_next", {osc_rst, osc_halt}, 2'b00);
        chk("s1_err", tmo_err, 0);

        sample(2'b11, 0, 1'b0, 1'b0, gn, ln, sn);
        chk("s2_gate", gn, 100);
        chk("s2_idx", sample_idx, 2);

        h0 = n_halt;
        sample(2'b11, 0, 1'b0, 1'b0, gn, ln, sn);
        chk("s3_idx", sample_idx, 0);
        chk("s3_halt", {osc_rst, osc_halt}, 2'b11);
        wait_for(2, 300, n, hit);
        chk("halt_end", hit, 1);
        chk("halt_len", n, 200);
        chk("halt_cnt", n_halt - h0, 200);
        chk("resume", {osc_rst, osc_halt}, 2'b00);

        sample(2'b01, 0, 1'b0, 1'b0, gn, ln, sn);
        chk("tmo_gate", gn, 100);
        chk("tmo_latch", ln, 8);
        chk("tmo_err", tmo_err, 1);
        chk("tmo_data", bus.tx_data, 64'hFFFFFFFF_00000011);
        chk("tmo_idx", sample_idx, 1);

        bus.cnt_latch = {32'hA5A5_0001, 32'h5A5A_0002};
        sample(2'b11, 50, 1'b1, 1'b0, gn, ln, sn);
        chk("busy_starts", sn, 1);
        chk("busy_idx", sample_idx, 2);
        chk("busy_data", bus.tx_data, 64'hA5A50001_5A5A0002);
        chk("err_sticky", tmo_err, 1);

        sample(2'b11, 0, 1'b0, 1'b1, gn, ln, sn);
        chk("drop_starts", sn, 1);
        chk("drop_idle", {osc_rst, osc_halt}, 2'b10);
        chk("drop_idx", sample_idx, 0);
        s0 = n_start;
        wait_for(0, 150, n, hit);
        chk("drop_no_latch", hit, 0);
        chk("drop_no_start", n_start - s0, 0);

        enable = 1'b1;
        tick();
        for (int i = 0; i < 39; i++) tick();
        chk("abort_in_gate", osc_rst, 0);
        enable = 1'b0;
        tick();
        chk("abort_idle", osc_rst, 1);
        s0 = n_start;
        wait_for(0, 150, n, hit);
        chk("abort_no_latch", hit, 0);
        chk("abort_no_start", n_start - s0, 0);

        enable = 1'b1;
        wait_for(0, 300, n, hit);
        chk("rl_latch", bus.latch_req, 1);
        chk("rl_err_held", tmo_err, 1);
        rst = 1'b1;
        #1;
        chk("rl_ctl", {osc_rst, osc_halt, bus.latch_req,
                       bus.tx_start, tmo_err}, 5'b10000);
        chk("rl_data", bus.tx_data, 0);
        chk("rl_idx", sample_idx, 0);
        enable = 1'b0;
        tick();
        rst = 1'b0;
        s0 = n_start;
        for (int i = 0; i < 50; i++) tick();
        chk("rl_quiet", n_start - s0, 0);
        chk("rl_idle", osc_rst, 1);

        enable = 1'b1;
        tick();
        sample(2'b11, 0, 1'b0, 1'b0, gn, ln, sn);
        chk("re_gate", gn, 100);
        chk("re_idx", sample_idx, 1);
        chk("re_err", tmo_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/osc_meas_seq.md
OSC_MEAS_SEQ -- requirements
Module: osc_meas_seq

Interface
REQ-001 Parameter GATE_CYC, default 10_000_000: gate window length in ref_clk cycles.
REQ-002 Parameter N_CH, default 2: number of oscillator channels.
REQ-003 Parameter CNT_W, default 32: per-channel count width.
REQ-004 Parameter STP_SMPL, default 30: samples per run before halt.
REQ-005 Parameter HALT_WIN, default 1: halt duration in gate windows.
REQ-006 Parameter ACK_TMO, default 64: max ref_clk cycles waiting for latch acks.
REQ-007 ref_clk  in  1  clock; all I/O synchronous to it.
REQ-008 rst  in  1  reset, asynchronous, active-high.
REQ-009 enable  in  1  run request (level).
REQ-010 osc_rst  out  1  clear oscillator counters.
REQ-011 osc_halt  out  1  stop oscillators.
REQ-012 latch_req  out  1  request snapshot of all channel counters.
REQ-013 latch_ack  in  N_CH  per-channel snapshot valid (level, ref_clk domain).
REQ-014 cnt_latch  in  N_CH*CNT_W  snapshots, channel 0 in LSBs.
REQ-015 tx_start  out  1  one-cycle UART start pulse.
REQ-016 tx_data  out  N_CH*CNT_W  frame payload, held stable outside CAPTURE.
REQ-017 tx_busy  in  1  UART busy; tx_done  in  1  one-cycle frame-complete pulse.
REQ-018 sample_idx  out  clog2(STP_SMPL)  samples sent in current run.
REQ-019 tmo_err  out  1  sticky ack-timeout flag.

Function
REQ-020 States: IDLE, GATE, LATCH, SEND, HALT; binary-encoded.
REQ-021 Outputs: osc_rst=1 in IDLE/SEND/HALT, else 0; osc_halt=1 in HALT only; latch_req=1 in LATCH only; all registered.
REQ-022 IDLE->GATE when enable=1; timer cleared on entry.
REQ-023 GATE lasts exactly GATE_CYC cycles (timer 0..GATE_CYC-1), then ->LATCH.
REQ-024 LATCH: when &latch_ack=1, capture cnt_latch into tx_data, ->SEND next cycle.
REQ-025 LATCH: if ACK_TMO cycles elapse without &latch_ack, set tmo_err, capture acked channels, load unacked channels with all-ones, ->SEND.
REQ-026 SEND: tx_start pulses exactly once, first cycle tx_busy=0; held off while tx_busy=1.
REQ-027 SEND: on tx_done after the start pulse, sample_idx increments; if new value == STP_SMPL ->HALT with sample_idx=0, else ->GATE.
REQ-028 tx_done seen before the tx_start pulse is ignored.
REQ-029 HALT lasts GATE_CYC*HALT_WIN cycles, then ->GATE.
REQ-030 enable=0 in GATE or HALT: ->IDLE next cycle, no latch, no frame; sample_idx cleared.
REQ-031 enable=0 in LATCH or SEND: current sample completes through tx_done, then ->IDLE.
REQ-032 Timer width clog2(GATE_CYC*HALT_WIN+1); no wrap inside any state.
REQ-033 tmo_err cleared only by rst.

Reset
REQ-034 On rst: state IDLE, timer 0, sample_idx 0, tx_data 0, tmo_err 0, latch_req 0, tx_start 0, osc_halt 0, osc_rst 1.
REQ-035 rst asserted mid-operation aborts immediately; no tx_start after deassert until enable.

Structure
REQ-036 Package osc_meas_pkg holds state enum and default CNT_W/N_CH constants.
REQ-037 One sub-module natural: osc_win_timer (loadable down-counter with terminal flag), shared by GATE, LATCH timeout and HALT.

Verification (GATE_CYC=100, N_CH=2, STP_SMPL=3, HALT_WIN=2, ACK_TMO=8)
REQ-038 enable=1, acks 2 cycles after latch_req, cnt 0x11/0x22 -> latch_req after 100 GATE cycles; tx_data=0x00000022_00000011; one tx_start.
REQ-039 Three samples -> sample_idx 1,2,0; osc_halt high exactly 200 cycles; then GATE resumes.
REQ-040 latch_ack=2'b01 only -> after 8 cycles tmo_err=1, tx_data upper word 0xFFFFFFFF.
REQ-041 tx_busy=1 for 50 cycles at SEND entry -> tx_start delayed to first tx_busy=0 cycle; spurious earlier tx_done ignored.
REQ-042 enable=0 at GATE cycle 40 -> IDLE next cycle, no tx_start; enable=0 during SEND -> frame finishes, then IDLE.
REQ-043 rst pulse during LATCH -> all outputs at reset values same cycle; tmo_err cleared.
